// File: rtl/fb_write_port.sv
// fb_write_port: framebuffer write port.
// Takes (x, y, colour) beats over a valid/ready handshake and runs them through
// a two-stage pipeline. S1 captures the beat and its bounds check. S2 holds the
// linear address y*H_RES + x and issues single-cycle writes to the RAM arbiter,
// stalling while the arbiter deasserts wr_ready. A beat marked in_last produces
// a one-cycle done pulse when it leaves S2.
// Optional feature macro: FB_WRITE_CLIP_EN. When it is defined, off-screen beats
// are clipped and counted in drop_count. When it is undefined, every beat is
// written and drop_count reads 0.
module fb_write_port #(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_x,
    input  logic [7:0]         in_y,
    input  logic [COLOR_W-1:0] in_color,
    input  logic               in_last,
    output logic               wr_en,
    input  logic               wr_ready,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic [15:0]        drop_count
);

    // Stage 1 registers
    logic               r_s1_valid;
    logic [7:0]         r_s1_x;
    logic [7:0]         r_s1_y;
    logic [COLOR_W-1:0] r_s1_color;
    logic               r_s1_last;
    logic               r_s1_keep;

    // Stage 2 registers
    logic               r_s2_valid;
    logic [ADDR_W-1:0]  r_s2_addr;
    logic [COLOR_W-1:0] r_s2_color;
    logic               r_s2_last;
    logic               r_s2_keep;

    logic               r_done;

    logic w_keep;
    logic w_s2_retire;
    logic w_s2_load;
    logic w_s1_load;
    logic w_accept;

`ifdef FB_WRITE_CLIP_EN
    assign w_keep = (32'(in_x) < 32'(H_RES)) && (32'(in_y) < 32'(V_RES));
`else
    assign w_keep = 1'b1;
`endif

    // A clipped beat leaves S2 without waiting for the arbiter.
    assign w_s2_retire = r_s2_valid & (wr_ready | ~r_s2_keep);
    assign w_s2_load   = ~r_s2_valid | w_s2_retire;
    assign w_s1_load   = ~r_s1_valid | w_s2_load;
    // Gated by reset so the upstream never sees a beat taken while in reset.
    assign in_ready    = reset & w_s1_load;
    assign w_accept    = in_valid & in_ready;

    assign wr_en   = r_s2_valid & r_s2_keep;
    assign wr_addr = r_s2_addr;
    assign wr_data = r_s2_color;
    assign busy    = r_s1_valid | r_s2_valid;
    assign done    = r_done;

    // S1: capture an accepted beat together with its bounds check.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_color <= '0;
            r_s1_last  <= 1'b0;
            r_s1_keep  <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_x     <= in_x;
                r_s1_y     <= in_y;
                r_s1_color <= in_color;
                r_s1_last  <= in_last;
                r_s1_keep  <= w_keep;
            end
        end
    end

    // S2: form the linear address. The registers hold still while stalled,
    // which keeps wr_addr/wr_data stable for the arbiter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_color <= '0;
            r_s2_last  <= 1'b0;
            r_s2_keep  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                // Full-width product, then truncated to the address width.
                r_s2_addr  <= ADDR_W'(32'(r_s1_y) * 32'(H_RES) + 32'(r_s1_x));
                r_s2_color <= r_s1_color;
                r_s2_last  <= r_s1_last;
                r_s2_keep  <= r_s1_keep;
            end
        end
    end

    // Completion pulse for the cycle after a last beat leaves S2.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_s2_retire & r_s2_last;
        end
    end

`ifdef FB_WRITE_CLIP_EN
    logic [15:0] r_drop_count;

    // Count clipped beats as they enter S1. The count saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_count <= '0;
        end else if (w_accept && !w_keep && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_fb_write_port.sv
// tb_fb_write_port: testbench for fb_write_port.
// Directed table vectors and hand-written multi-cycle sequences, plus a random
// phase. A transaction-level model runs underneath all of them: an in-order
// queue holding at most two beats. A beat becomes visible two edges after it
// is accepted. Honours FB_WRITE_CLIP_EN the same way the design does.
module tb_fb_write_port;

    localparam int H = 160;
    localparam int V = 120;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic [2:0]  in_color;
    logic        in_last;
    logic        wr_en;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic        busy;
    logic        done;
    logic [15:0] drop_count;

    fb_write_port dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_color   (in_color),
        .in_last    (in_last),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int addr;
        int color;
        bit last;
        bit keep;
        int acc_cyc;
    } beat_t;

    beat_t q[$];
    int    cyc      = 0;
    int    drop_exp = 0;
    bit    done_exp = 1'b0;

    function automatic bit m_keep(input int x, input int y);
`ifdef FB_WRITE_CLIP_EN
        return (x < H) && (y < V);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int m_addr(input int x, input int y);
        return (y * H + x) % 32768;
    endfunction

    // The oldest beat sits at the write port once two edges have passed since it was accepted.
    function automatic bit head_visible();
        return (q.size() != 0) && (cyc >= q[0].acc_cyc + 2);
    endfunction

    always @(posedge clk) begin
        bit vis;
        bit ret;
        bit rdy;
        bit acc;
        beat_t b;
        vis = head_visible();
        ret = vis && (wr_ready || !q[0].keep);
        rdy = (q.size() < 2) || ret;
        acc = in_valid && rdy;
        if (!reset) begin
            q.delete();
            drop_exp = 0;
            done_exp = 1'b0;
        end else begin
            done_exp = ret && q[0].last;
            if (ret) void'(q.pop_front());
            if (acc) begin
                b.addr    = m_addr(int'(in_x), int'(in_y));
                b.color   = int'(in_color);
                b.last    = in_last;
                b.keep    = m_keep(int'(in_x), int'(in_y));
                b.acc_cyc = cyc;
                q.push_back(b);
                if (!b.keep && drop_exp != 16'hFFFF) drop_exp++;
            end
        end
        cyc++;
    end

    // Monitor: compare every output with the model on the falling edge.
    always @(negedge clk) begin
        bit vis;
        bit exp_wr;
        bit exp_rdy;
        if (mon_en) begin
            vis     = head_visible();
            exp_wr  = vis && q[0].keep;
            exp_rdy = reset && ((q.size() < 2) || (vis && (wr_ready || !q[0].keep)));
            check("in_ready", in_ready, exp_rdy);
            check("wr_en", wr_en, exp_wr);
            if (exp_wr && wr_en) begin
                check("wr_addr", wr_addr, q[0].addr);
                check("wr_data", wr_data, q[0].color);
            end
            check("done", done, done_exp);
            check("busy", busy, q.size() != 0);
            check("drop_count", drop_count, drop_exp);
            if (wr_en && wr_ready) n_writes++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int x, input int y, input int c, input bit last);
        in_valid = 1'b1;
        in_x     = 8'(x);
        in_y     = 8'(y);
        in_color = 3'(c);
        in_last  = last;
    endtask

    // Present a beat and hold it until it is taken, bounded at 50 cycles.
    task automatic send(input int x, input int y, input int c, input bit last);
        bit got = 1'b0;
        int n   = 0;
        drive(x, y, c, last);
        while (!got && n < 50) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("send_accept", got, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        wr_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_busy", busy, 1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        int x;
        int y;
        int c;
        bit last;
        bit exp_wr;
        int exp_addr;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        bit clip;
`ifdef FB_WRITE_CLIP_EN
        clip = 1'b1;
`else
        clip = 1'b0;
`endif
        tbl[0] = '{0,   0,   1, 1'b0, 1'b1,  0};
        tbl[1] = '{0,   1,   2, 1'b0, 1'b1,  160};
        tbl[2] = '{159, 119, 7, 1'b1, 1'b1,  19199};
        tbl[3] = '{159, 0,   3, 1'b0, 1'b1,  159};
        tbl[4] = '{0,   119, 4, 1'b0, 1'b1,  19040};
        tbl[5] = '{160, 0,   5, 1'b0, !clip, 160};
        tbl[6] = '{0,   120, 6, 1'b0, !clip, 19200};
        tbl[7] = '{255, 255, 2, 1'b1, !clip, 8287};

        // Reset held for two cycles with a beat offered.
        reset    = 1'b0;
        wr_ready = 1'b1;
        drive(5, 5, 3, 1'b1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop_count, 16'd0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_wr_addr", wr_addr, 15'd0);
        check("rst_wr_data", wr_data, 3'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors, one beat at a time through an idle pipeline.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].last);
            check("tbl_in_ready", in_ready, 1'b1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("tbl_wr_en", wr_en, tbl[i].exp_wr);
            if (tbl[i].exp_wr) begin
                check("tbl_wr_addr", wr_addr, tbl[i].exp_addr);
                check("tbl_wr_data", wr_data, tbl[i].c);
            end
            @(posedge clk);
            #1;
            check("tbl_done", done, tbl[i].last);
        end
        drain();

        // Back-to-back stream: writes on consecutive cycles, then a single done.
        drive(0, 0, 1, 1'b0);
        @(posedge clk); #1;
        drive(0, 1, 2, 1'b0);
        @(posedge clk); #1;
        drive(159, 119, 7, 1'b1);
        check("strm_addr0", wr_addr, 15'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("strm_addr1", wr_addr, 15'd160);
        @(posedge clk); #1;
        check("strm_addr2", wr_addr, 15'd19199);
        check("strm_done_early", done, 1'b0);
        @(posedge clk); #1;
        check("strm_done", done, 1'b1);
        @(posedge clk); #1;
        check("strm_done_once", done, 1'b0);
        drain();

        // Backpressure: the arbiter stalls for three cycles while four beats stream in.
        wr_ready = 1'b0;
        drive(1, 2, 1, 1'b0);
        @(posedge clk); #1;
        drive(3, 4, 2, 1'b0);
        @(posedge clk); #1;
        drive(5, 6, 3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("bp_wr_en", wr_en, 1'b1);
            check("bp_addr_hold", wr_addr, 15'd321);
            check("bp_data_hold", wr_data, 3'd1);
            check("bp_in_ready", in_ready, 1'b0);
            if (k < 2) begin
                @(posedge clk); #1;
            end
        end
        wr_ready = 1'b1;
        send(5, 6, 3, 1'b0);
        send(7, 8, 4, 1'b1);
        drain();

        // Off-screen beats starting from a fresh drop count.
        pulse_reset();
        send(160, 0, 5, 1'b0);
        send(0, 120, 6, 1'b0);
        send(255, 255, 2, 1'b1);
        drain();
        check("clip_drop_count", drop_count, clip ? 16'd3 : 16'd0);

        // Random traffic with random arbiter backpressure.
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom % 4) != 0;
            in_x     = ($urandom % 2) ? 8'($urandom_range(0, H - 1)) : 8'($urandom_range(0, 255));
            in_y     = ($urandom % 2) ? 8'($urandom_range(0, V - 1)) : 8'($urandom_range(0, 255));
            in_color = 3'($urandom);
            in_last  = ($urandom % 8) == 0;
            wr_ready = ($urandom % 3) != 0;
            @(posedge clk);
            #1;
        end
        drain();

`ifdef FB_WRITE_CLIP_EN
        // Saturation: more clipped beats than the counter can hold.
        drive(200, 0, 1, 1'b0);
        repeat (65540) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sat_drop_count", drop_count, 16'hFFFF);
        drain();
`endif

        // Reset during a stall with two beats buffered.
        wr_ready = 1'b0;
        send(10, 10, 5, 1'b0);
        send(11, 10, 6, 1'b1);
        check("ms_stalled_wr_en", wr_en, 1'b1);
        check("ms_stalled_busy", busy, 1'b1);
        w0 = n_writes;
        pulse_reset();
        check("ms_wr_en", wr_en, 1'b0);
        check("ms_busy", busy, 1'b0);
        wr_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("ms_no_write", n_writes - w0, 0);
        check("ms_done", done, 1'b0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
